// File: rtl/vga_scan_out.sv
// Purpose : VGA 640x480@60 scan generator (x/y, endofframe) and registered sync/colour output stage.
// Latency : hsync/vsync/video_on/RGB lag x/y by one pixel tick; endofframe is registered with x/y.
// Backpr. : none; free-running raster, and all state holds between pixel ticks.
//
// Ports:
//   clk                     system clock (pixel clock, or 2x pixel clock with VGA_SCAN_CLK_DIV2_EN)
//   reset                   synchronous active-low reset
//   ball_on/ball_rgb        ball layer flag and colour for the current x,y (combinational from x,y)
//   paddle_on/paddle_rgb    paddle layer flag and colour for the current x,y
//   x, y                    current pixel column / line
//   endofframe              high while y >= V_DISPLAY; registered so it can safely be used as a clock
//   hsync, vsync            active-low syncs
//   video_on                registered display-area flag
//   red, green, blue        pixel colour {r[2:0], g[2:0], b[1:0]}
//
// Option macro: VGA_SCAN_CLK_DIV2_EN -- divide clk by two to form the pixel tick.
module vga_scan_out #(
    parameter int         H_DISPLAY = 640,
    parameter int         H_FRONT   = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BACK    = 48,
    parameter int         V_DISPLAY = 480,
    parameter int         V_FRONT   = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BACK    = 33,
    parameter logic [7:0] BG_RGB    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_on,
    input  logic [7:0] ball_rgb,
    input  logic       paddle_on,
    input  logic [7:0] paddle_rgb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       endofframe,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic ptick;

`ifdef VGA_SCAN_CLK_DIV2_EN
    // Divider starts at 0 out of reset, so the first tick lands on the
    // second clock after release.
    logic div_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    assign ptick = div_q;
`else
    assign ptick = 1'b1;
`endif

    logic       x_wrap;
    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        x_wrap = (x == H_MAX);
        x_next = x_wrap ? 10'd0 : x + 10'd1;
        y_next = y;
        if (x_wrap) begin
            y_next = (y == V_MAX) ? 10'd0 : y + 10'd1;
        end
    end

    logic       vid_raw;
    logic       hs_raw;
    logic       vs_raw;
    logic [7:0] pix_rgb;

    always_comb begin
        vid_raw = (x < H_VIS) && (y < V_VIS);
        hs_raw  = !((x >= HS_START) && (x <= HS_END));
        vs_raw  = !((y >= VS_START) && (y <= VS_END));
        // Blanking wins over every layer; ball sits above paddle.
        if (!vid_raw) begin
            pix_rgb = 8'h00;
        end else if (ball_on) begin
            pix_rgb = ball_rgb;
        end else if (paddle_on) begin
            pix_rgb = paddle_rgb;
        end else begin
            pix_rgb = BG_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x          <= 10'd0;
            y          <= 10'd0;
            endofframe <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b0;
            red        <= 3'd0;
            green      <= 3'd0;
            blue       <= 2'd0;
        end else if (ptick) begin
            x          <= x_next;
            y          <= y_next;
            // Loaded from y_next so it changes on the same edge as y and
            // comes straight off a flop (no decode glitches downstream).
            endofframe <= (y_next >= V_VIS);
            hsync      <= hs_raw;
            vsync      <= vs_raw;
            video_on   <= vid_raw;
            red        <= pix_rgb[7:5];
            green      <= pix_rgb[4:2];
            blue       <= pix_rgb[1:0];
        end
    end

endmodule
